// File: rtl/run_ctrl_if.sv
// Handshake bundle between a run requester and the run_ctrl sequencer.
// Latency: none, this is wiring only.
// Backpressure: none; the req/done four-phase handshake provides the flow control.
// Ports: req/core_done come from the host/core side (master);
//        core_rst/run/done/timeout/cycle_cnt are produced by run_ctrl (slave).
interface run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req;
  logic             core_done;
  logic             core_rst;
  logic             run;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output req, core_done,
    input  core_rst, run, done, timeout, cycle_cnt
  );

  modport slave (
    input  req, core_done,
    output core_rst, run, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/run_ctrl.sv
// Sequences one processor run: park core in reset, release it, count cycles, report done/timeout.
// Latency: req rise -> run rise is RST_CYC+1 cycles; core_done sampled -> done rise is 1 cycle.
// Backpressure: four-phase req/done handshake; done holds until req drops, req low aborts a run.
// Ports: clk, reset (async active-low), bus (run_ctrl_if.slave):
//        req, core_done in; core_rst, run, done, timeout, cycle_cnt out.
module run_ctrl #(
  parameter int          CNT_W   = 16,
  parameter int          RST_CYC = 2,
  parameter int unsigned MAX_CYC = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESET  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Last value of the reset-hold counter before moving to RUN.
  localparam logic [3:0]       RST_LAST = 4'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rst_cnt_q, rst_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_inc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rst_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_cnt_q <= rst_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_cnt_d = rst_cnt_q;
    timeout_d = timeout_q;
    cnt_inc   = cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d   = S_RESET;
          cnt_d     = '0;
          rst_cnt_d = '0;
          timeout_d = 1'b0;
        end
      end

      S_RESET: begin
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end

      S_RUN: begin
        // Every RUN cycle is counted, including the one that ends the run.
        // The budget check exits exactly at CNT_MAX, so the counter cannot wrap.
        cnt_d = cnt_inc;
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (bus.core_done) begin
          state_d = S_FINISH;
        end else if (cnt_inc == CNT_MAX) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end
      end

      S_FINISH: begin
        if (!bus.req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: outputs depend only on flops, never on inputs.
  always_comb begin
    bus.core_rst  = (state_q != S_RUN);
    bus.run       = (state_q == S_RUN);
    bus.done      = (state_q == S_FINISH);
    bus.timeout   = timeout_q;
    bus.cycle_cnt = cnt_q;
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int A_RST = 2;
  localparam int B_MAX = 8;

  logic clk = 1'b0;
  logic reset;
  logic req;
  logic core_done;
  logic sel;  // 0: observe/drive dut_a (default budget), 1: dut_b (budget 8)

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  run_ctrl_if #(.CNT_W(16)) if_a ();
  run_ctrl_if #(.CNT_W(16)) if_b ();

  assign if_a.req       = sel ? 1'b0 : req;
  assign if_a.core_done = sel ? 1'b0 : core_done;
  assign if_b.req       = sel ? req : 1'b0;
  assign if_b.core_done = sel ? core_done : 1'b0;

  run_ctrl #(.CNT_W(16), .RST_CYC(A_RST), .MAX_CYC(16'hFFFF)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );

  run_ctrl #(.CNT_W(16), .RST_CYC(A_RST), .MAX_CYC(B_MAX)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  logic        o_core_rst, o_run, o_done, o_timeout;
  logic [15:0] o_cnt;

  always_comb begin
    o_core_rst = sel ? if_b.core_rst  : if_a.core_rst;
    o_run      = sel ? if_b.run       : if_a.run;
    o_done     = sel ? if_b.done      : if_a.done;
    o_timeout  = sel ? if_b.timeout   : if_a.timeout;
    o_cnt      = sel ? if_b.cycle_cnt : if_a.cycle_cnt;
  end

  always #5 clk = ~clk;

  // Scoreboard: every done rising edge pops one expected result.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (o_done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done cnt=%0d timeout=%0b", o_cnt, o_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (o_cnt !== mon_e.cnt) begin
          errors++; $display("FAIL sb_cycle_cnt got=%0d exp=%0d", o_cnt, mon_e.cnt);
        end
        checks++;
        if (o_timeout !== mon_e.to) begin
          errors++; $display("FAIL sb_timeout got=%0b exp=%0b", o_timeout, mon_e.to);
        end
        checks++;
        if (o_core_rst !== 1'b1) begin
          errors++; $display("FAIL sb_core_rst got=%0b exp=1", o_core_rst);
        end
        checks++;
        if (o_run !== 1'b0) begin
          errors++; $display("FAIL sb_run got=%0b exp=0", o_run);
        end
      end
    end
    prev_done = o_done;
  end

  // Stimulus only. Call at a negedge; returns at the negedge after run falls.
  // lat: posedges from req sampling until run seen; run_len: negedges with run high.
  task automatic drive_run(input int done_on, input int abort_on,
                           output int lat, output int run_len, output logic [15:0] cnt0);
    req = 1'b1;
    core_done = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!o_run && lat < 40);
    cnt0 = o_cnt;
    run_len = 0;
    while (o_run && run_len < 100) begin
      run_len++;
      core_done = (run_len == done_on);
      if (run_len == abort_on) req = 1'b0;
      @(negedge clk);
    end
    core_done = 1'b0;
  endtask

  task automatic test_reset;
    sel = 1'b0; req = 1'b0; core_done = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (o_core_rst !== 1'b1 || o_run !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got rst=%0b run=%0b done=%0b exp 1/0/0", o_core_rst, o_run, o_done);
    end
    checks++;
    if (o_timeout !== 1'b0 || o_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_status got to=%0b cnt=%0d exp 0/0", o_timeout, o_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_core_rst !== 1'b1 || o_run !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rst=%0b run=%0b exp 1/0", o_core_rst, o_run);
    end
  endtask

  task automatic test_idle_ignore;
    core_done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_run !== 1'b0 || o_done !== 1'b0 || o_core_rst !== 1'b1) begin
      errors++; $display("FAIL idle_ignore got run=%0b done=%0b rst=%0b exp 0/0/1", o_run, o_done, o_core_rst);
    end
    core_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    int lat, rl;
    logic [15:0] c0;
    sel = 1'b0;
    exp_q.push_back('{cnt: 16'd10, to: 1'b0});
    drive_run(10, 0, lat, rl, c0);
    checks++;
    if (lat !== A_RST + 1) begin errors++; $display("FAIL nom_latency got=%0d exp=%0d", lat, A_RST + 1); end
    checks++;
    if (rl !== 10) begin errors++; $display("FAIL nom_run_len got=%0d exp=10", rl); end
    checks++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL nom_done got=%0b exp=1", o_done); end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_cnt !== 16'd10 || o_core_rst !== 1'b1) begin
      errors++; $display("FAIL nom_release got done=%0b cnt=%0d rst=%0b exp 0/10/1", o_done, o_cnt, o_core_rst);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat, rl;
    logic [15:0] c0;
    sel = 1'b1;
    @(negedge clk);
    exp_q.push_back('{cnt: 16'(B_MAX), to: 1'b1});
    drive_run(0, 0, lat, rl, c0);
    checks++;
    if (rl !== B_MAX) begin errors++; $display("FAIL to_run_len got=%0d exp=%0d", rl, B_MAX); end
    repeat (3) @(negedge clk);
    checks++;
    if (o_done !== 1'b1 || o_timeout !== 1'b1 || o_cnt !== 16'(B_MAX)) begin
      errors++; $display("FAIL to_hold got done=%0b to=%0b cnt=%0d exp 1/1/%0d", o_done, o_timeout, o_cnt, B_MAX);
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_cnt !== 16'(B_MAX)) begin
      errors++; $display("FAIL to_release got done=%0b cnt=%0d exp 0/%0d", o_done, o_cnt, B_MAX);
    end
  endtask

  task automatic test_tie;
    int lat, rl;
    logic [15:0] c0;
    sel = 1'b1;
    exp_q.push_back('{cnt: 16'(B_MAX), to: 1'b0});
    drive_run(B_MAX, 0, lat, rl, c0);
    checks++;
    if (c0 !== 16'd0 || rl !== B_MAX) begin
      errors++; $display("FAIL tie_run got cnt0=%0d len=%0d exp 0/%0d", c0, rl, B_MAX);
    end
    checks++;
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL tie_timeout got=%0b exp=0", o_timeout); end
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int lat, rl;
    logic [15:0] c0;
    sel = 1'b0;
    drive_run(0, 3, lat, rl, c0);
    checks++;
    if (rl !== 3) begin errors++; $display("FAIL abort_run_len got=%0d exp=3", rl); end
    checks++;
    if (o_cnt !== 16'd3 || o_core_rst !== 1'b1 || o_done !== 1'b0 || o_timeout !== 1'b0) begin
      errors++; $display("FAIL abort_state got cnt=%0d rst=%0b done=%0b to=%0b exp 3/1/0/0", o_cnt, o_core_rst, o_done, o_timeout);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_run !== 1'b0) begin
      errors++; $display("FAIL abort_idle got done=%0b run=%0b exp 0/0", o_done, o_run);
    end
  endtask

  task automatic test_async_reset;
    int n;
    sel = 1'b0;
    req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_run && n < 20);
    repeat (3) @(negedge clk);
    checks++;
    if (o_run !== 1'b1 || o_cnt !== 16'd3) begin
      errors++; $display("FAIL async_pre got run=%0b cnt=%0d exp 1/3", o_run, o_cnt);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (o_core_rst !== 1'b1 || o_run !== 1'b0 || o_cnt !== 16'd0 || o_done !== 1'b0) begin
      errors++; $display("FAIL async_reset got rst=%0b run=%0b cnt=%0d done=%0b exp 1/0/0/0", o_core_rst, o_run, o_cnt, o_done);
    end
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_with_req;
    int lat;
    reset = 1'b0;
    req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!o_run && lat < 40);
    checks++;
    if (lat !== A_RST + 1) begin errors++; $display("FAIL rstreq_latency got=%0d exp=%0d", lat, A_RST + 1); end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (o_run !== 1'b0 || o_done !== 1'b0 || o_cnt !== 16'd1) begin
      errors++; $display("FAIL rstreq_abort got run=%0b done=%0b cnt=%0d exp 0/0/1", o_run, o_done, o_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, rl;
    logic [15:0] c0;
    sel = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back('{cnt: 16'd10, to: 1'b0});
      drive_run(10, 0, lat, rl, c0);
      checks++;
      if (lat !== A_RST + 1 || rl !== 10 || c0 !== 16'd0) begin
        errors++; $display("FAIL b2b_run%0d got lat=%0d len=%0d cnt0=%0d exp %0d/10/0", r, lat, rl, c0, A_RST + 1);
      end
      req = 1'b0;
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0) begin errors++; $display("FAIL b2b_release%0d got done=%0b exp=0", r, o_done); end
    end
    @(negedge clk);
  endtask

  task automatic test_final;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_nominal();
    test_timeout();
    test_tie();
    test_abort();
    test_async_reset();
    test_reset_with_req();
    test_back_to_back();
    test_final();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
